// File: rtl/s2p_frame_ctrl_if.sv
// Serial-to-parallel frame receiver bus: serial input side plus the byte handshake.
interface s2p_frame_ctrl_if;
  logic       D;
  logic       DV;
  logic       ACK;
  logic [7:0] Q;
  logic       DR;
  logic       BUSY;
  logic       PERR;
  logic       FERR;
  logic       OVR;

  // Producer/consumer side: drives the line and the acknowledge.
  modport master (output D, DV, ACK, input Q, DR, BUSY, PERR, FERR, OVR);
  // Receiver side.
  modport slave  (input D, DV, ACK, output Q, DR, BUSY, PERR, FERR, OVR);
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Serial frame receiver: start bit, 8 data bits MSB first, optional even
// parity and a stop bit. The completed byte is held in Q with a DR/ACK
// handshake and a sticky overrun flag. An idle watchdog aborts stalled frames.
module s2p_frame_ctrl #(
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic         CLK,
  input  logic         CLR,
  s2p_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HI, LO, PAR, STOP} state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  idle_q, idle_d;
  logic [3:0]  sh_q, sh_d;
  logic [3:0]  hi_q, hi_d;
  logic        bad_q, bad_d;
  logic [7:0]  q_q, q_d;
  logic        dr_q, dr_d;
  logic        ovr_q, ovr_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        deliver;
  logic [7:0]  byte_w;

  // The upper nibble is frozen after HI; the shift stage then holds the lower one.
  assign byte_w = {hi_q, sh_q};

  // Frame sequencing, idle watchdog and error pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    sh_d    = sh_q;
    hi_d    = hi_q;
    bad_d   = bad_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    deliver = 1'b0;
    if (state_q != IDLE && idle_q == TO8) begin
      // Watchdog abort wins over any sample on this edge.
      state_d = IDLE;
      ferr_d  = 1'b1;
      idle_d  = 8'd0;
      cnt_d   = 2'd0;
    end else if (state_q != IDLE && !bus.DV) begin
      idle_d = idle_q + 8'd1;
    end else if (bus.DV) begin
      idle_d = 8'd0;
      case (state_q)
        IDLE: begin
          if (bus.D) begin
            state_d = HI;
            cnt_d   = 2'd0;
            bad_d   = 1'b0;
          end
        end
        HI: begin
          sh_d  = {sh_q[2:0], bus.D};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            hi_d    = {sh_q[2:0], bus.D};
            state_d = LO;
          end
        end
        LO: begin
          sh_d  = {sh_q[2:0], bus.D};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = PARITY_EN ? PAR : STOP;
        end
        PAR: begin
          bad_d   = (bus.D != ^byte_w);
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bus.D)      ferr_d  = 1'b1;
          else if (bad_q) perr_d  = 1'b1;
          else            deliver = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register: load, same-edge reload on ACK, or overrun.
  always_comb begin
    q_d   = q_q;
    dr_d  = dr_q;
    ovr_d = ovr_q;
    if (deliver) begin
      if (!dr_q || bus.ACK) begin
        q_d  = byte_w;
        dr_d = 1'b1;
        if (bus.ACK) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.ACK && dr_q) begin
      dr_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously by CLR.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idle_q  <= 8'd0;
      sh_q    <= 4'd0;
      hi_q    <= 4'd0;
      bad_q   <= 1'b0;
      q_q     <= 8'h00;
      dr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      sh_q    <= sh_d;
      hi_q    <= hi_d;
      bad_q   <= bad_d;
      q_q     <= q_d;
      dr_q    <= dr_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.DR   = dr_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.PERR = perr_q;
  assign bus.FERR = ferr_q;
  assign bus.OVR  = ovr_q;

endmodule
